// File: rtl/cu_vertex_cache_arbiter_pkg.sv
// Shared types and constants for the vertex cache arbiter.
// Holds the command/response/data line structs exchanged with the cache
// and the requesters, the arbiter state enum, and the default sizing.
package cu_vertex_cache_arbiter_pkg;

  localparam int VERTEX_CACHE_ARB_REQUESTORS = 4;
  localparam int VERTEX_CACHE_ARB_FIFO_DEPTH = 8;
  localparam int VERTEX_CACHE_ARB_ID_BITS    = $clog2(VERTEX_CACHE_ARB_REQUESTORS);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } VertexCacheArbState;

  typedef struct packed {
    logic [VERTEX_CACHE_ARB_ID_BITS-1:0] cu_id;
    logic [31:0]                         address;
    logic [7:0]                          tag;
  } CommandMeta;

  typedef struct packed {
    CommandMeta cmd;
    logic [7:0] burst_length;
  } CommandPayload;

  typedef struct packed {
    logic          valid;
    CommandPayload payload;
  } CommandBufferLine;

  typedef struct packed {
    CommandMeta cmd;
  } ResponsePayload;

  typedef struct packed {
    logic           valid;
    ResponsePayload payload;
  } ResponseBufferLine;

  typedef struct packed {
    CommandMeta  cmd;
    logic [63:0] data;
  } ReadWriteDataPayload;

  typedef struct packed {
    logic                valid;
    ReadWriteDataPayload payload;
  } ReadWriteDataLine;

endpackage

// File: rtl/cu_vertex_cache_arbiter_fifo.sv
// Per-requester command buffer: synchronous FIFO with occupancy count.
// Ports:
//   clock, rst_in       clock and async active-high reset
//   push, push_data     write request; ignored while full
//   pop, pop_data       read request; pop_data always shows the head entry
//   empty, full, count  occupancy status
module cu_vertex_cache_arbiter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/cu_vertex_cache_arbiter.sv
// Shares one vertex cache between NUM_REQUESTORS read requesters.
// Commands are buffered per requester, granted round-robin (one per cycle),
// stamped with the requester id and sent to the cache. Hits are routed back
// by id, misses forwarded to the memory read path. In-flight accesses are
// bounded by MAX_OUTSTANDING; dropping enabled_in drains queued work first.
//
// state    | meaning
// DISABLED | idle, no grants, drained_out=1
// RUN      | accepting and granting commands
// DRAIN    | no new commands accepted, queued/in-flight work finishing
//
// Ports:
//   clock, rst_in, enabled_in          clock, async reset, run enable
//   read_command_in / read_ready_out   per-requester command in, registered ready
//   cache_command_out                  granted command to the cache
//   cache_miss_command_in              miss command from the cache
//   cache_response_in, cache_data_*_in hit response and data from the cache
//   read_command_out                   miss command to memory read path
//   read_response_out, read_data_*_out per-requester routed hit response/data
//   outstanding_out, drained_out       in-flight count, drain done
module cu_vertex_cache_arbiter
  import cu_vertex_cache_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTORS  = VERTEX_CACHE_ARB_REQUESTORS,
  parameter int REQ_FIFO_DEPTH  = VERTEX_CACHE_ARB_FIFO_DEPTH,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_BITS         = $clog2(NUM_REQUESTORS)
) (
  input  logic                             clock,
  input  logic                             rst_in,
  input  logic                             enabled_in,
  input  CommandBufferLine                 read_command_in   [NUM_REQUESTORS],
  output logic                             read_ready_out    [NUM_REQUESTORS],
  output CommandBufferLine                 cache_command_out,
  input  CommandBufferLine                 cache_miss_command_in,
  input  ResponseBufferLine                cache_response_in,
  input  ReadWriteDataLine                 cache_data_0_in,
  input  ReadWriteDataLine                 cache_data_1_in,
  output CommandBufferLine                 read_command_out,
  output ResponseBufferLine                read_response_out [NUM_REQUESTORS],
  output ReadWriteDataLine                 read_data_0_out   [NUM_REQUESTORS],
  output ReadWriteDataLine                 read_data_1_out   [NUM_REQUESTORS],
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_out,
  output logic                             drained_out
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SUM_W = OUT_W + 1;
  localparam int CNT_W = $clog2(REQ_FIFO_DEPTH) + 1;
  localparam int PAY_W = $bits(CommandPayload);

  VertexCacheArbState state, state_next;

  logic [NUM_REQUESTORS-1:0] fifo_empty;
  logic [NUM_REQUESTORS-1:0] fifo_full;
  logic [NUM_REQUESTORS-1:0] fifo_pop;
  logic [NUM_REQUESTORS-1:0] nonempty;
  logic [NUM_REQUESTORS-1:0] hit_sel;
  logic [CNT_W-1:0]          fifo_count [NUM_REQUESTORS];
  logic [PAY_W-1:0]          fifo_dout  [NUM_REQUESTORS];

  logic [ID_BITS-1:0] rr_ptr;
  logic [ID_BITS-1:0] winner;
  logic               any_req;
  logic               room;
  logic               grant;
  logic               underflow;
  CommandPayload      issue_payload;
  logic [SUM_W-1:0]   out_ext;
  logic [SUM_W-1:0]   retire_cnt;
  logic [SUM_W-1:0]   out_after_retire;
  logic [SUM_W-1:0]   out_next_ext;

  // First non-empty requester at or above ptr, wrapping. Returns {found, index}.
  function automatic logic [ID_BITS:0] rr_select(input logic [NUM_REQUESTORS-1:0] req,
                                                  input logic [ID_BITS-1:0]        ptr);
    logic [ID_BITS-1:0] idx;
    logic [ID_BITS-1:0] sel;
    logic               found;
    sel   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQUESTORS; off++) begin
      idx = ptr + ID_BITS'(off);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  for (genvar g = 0; g < NUM_REQUESTORS; g++) begin : g_req
    cu_vertex_cache_arbiter_fifo #(
      .WIDTH (PAY_W),
      .DEPTH (REQ_FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .rst_in    (rst_in),
      .push      (read_command_in[g].valid),
      .push_data (read_command_in[g].payload),
      .pop       (fifo_pop[g]),
      .pop_data  (fifo_dout[g]),
      .empty     (fifo_empty[g]),
      .full      (fifo_full[g]),
      .count     (fifo_count[g])
    );

    assign nonempty[g] = ~fifo_empty[g];
    assign hit_sel[g]  = (cache_response_in.payload.cmd.cu_id == VERTEX_CACHE_ARB_ID_BITS'(g));

    a_no_push_when_full: assert property (@(posedge clock) disable iff (rst_in)
      !(read_command_in[g].valid && fifo_full[g]));
  end

  always_comb begin
    state_next = state;
    case (state)
      DISABLED: if (enabled_in) state_next = RUN;
      RUN:      if (!enabled_in) state_next = DRAIN;
      DRAIN: begin
        if (enabled_in)
          state_next = RUN;
        else if ((&fifo_empty) && (outstanding_out == '0))
          state_next = DISABLED;
      end
      default:  state_next = DISABLED;
    endcase
  end

  // A retire in the same cycle frees a slot for this cycle's grant.
  always_comb begin
    {any_req, winner} = rr_select(nonempty, rr_ptr);
    out_ext          = SUM_W'(outstanding_out);
    retire_cnt       = SUM_W'(cache_response_in.valid) + SUM_W'(cache_miss_command_in.valid);
    out_after_retire = (retire_cnt > out_ext) ? '0 : (out_ext - retire_cnt);
    room             = (out_after_retire < SUM_W'(MAX_OUTSTANDING));
    grant            = ((state == RUN) || (state == DRAIN)) && any_req && room;
    underflow        = (retire_cnt > (out_ext + SUM_W'(grant)));
    out_next_ext     = underflow ? '0 : (out_ext + SUM_W'(grant) - retire_cnt);
    issue_payload    = CommandPayload'(fifo_dout[winner]);
    issue_payload.cmd.cu_id = VERTEX_CACHE_ARB_ID_BITS'(winner);
    fifo_pop         = '0;
    fifo_pop[winner] = grant;
  end

  a_no_underflow: assert property (@(posedge clock) disable iff (rst_in) !underflow);

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      state             <= DISABLED;
      rr_ptr            <= '0;
      outstanding_out   <= '0;
      cache_command_out <= '0;
      read_command_out  <= '0;
    end else begin
      state            <= state_next;
      outstanding_out  <= OUT_W'(out_next_ext);
      read_command_out <= cache_miss_command_in;
      cache_command_out.valid <= grant;
      if (grant) begin
        cache_command_out.payload <= issue_payload;
        rr_ptr                    <= winner + ID_BITS'(1);
      end
    end
  end

  // Ready follows the upcoming state so requesters stop pushing as soon as
  // a drain begins; the occupancy threshold leaves two cycles of slack for
  // commands already in flight from the requester.
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REQUESTORS; i++) begin
        read_ready_out[i]    <= 1'b0;
        read_response_out[i] <= '0;
        read_data_0_out[i]   <= '0;
        read_data_1_out[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQUESTORS; i++) begin
        read_ready_out[i] <= (state_next == RUN) &&
                             (fifo_count[i] <= CNT_W'(REQ_FIFO_DEPTH - 3));
        read_response_out[i].valid   <= cache_response_in.valid & hit_sel[i];
        read_response_out[i].payload <= cache_response_in.payload;
        read_data_0_out[i].valid     <= cache_data_0_in.valid & hit_sel[i];
        read_data_0_out[i].payload   <= cache_data_0_in.payload;
        read_data_1_out[i].valid     <= cache_data_1_in.valid & hit_sel[i];
        read_data_1_out[i].payload   <= cache_data_1_in.payload;
      end
    end
  end

  assign drained_out = (state == DISABLED);

endmodule

// File: tb/tb_cu_vertex_cache_arbiter.sv
module tb_cu_vertex_cache_arbiter;
  import cu_vertex_cache_arbiter_pkg::*;

  localparam int N = 4;

  logic              clock = 1'b0;
  logic              rst_in = 1'b1;
  logic              enabled_in = 1'b0;
  CommandBufferLine  read_command_in   [N];
  logic              read_ready_out    [N];
  CommandBufferLine  cache_command_out;
  CommandBufferLine  cache_miss_command_in;
  ResponseBufferLine cache_response_in;
  ReadWriteDataLine  cache_data_0_in;
  ReadWriteDataLine  cache_data_1_in;
  CommandBufferLine  read_command_out;
  ResponseBufferLine read_response_out [N];
  ReadWriteDataLine  read_data_0_out   [N];
  ReadWriteDataLine  read_data_1_out   [N];
  logic [3:0]        outstanding_out;
  logic              drained_out;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cu_vertex_cache_arbiter #(
    .NUM_REQUESTORS (N),
    .REQ_FIFO_DEPTH (8),
    .MAX_OUTSTANDING(8)
  ) dut (
    .clock                 (clock),
    .rst_in                (rst_in),
    .enabled_in            (enabled_in),
    .read_command_in       (read_command_in),
    .read_ready_out        (read_ready_out),
    .cache_command_out     (cache_command_out),
    .cache_miss_command_in (cache_miss_command_in),
    .cache_response_in     (cache_response_in),
    .cache_data_0_in       (cache_data_0_in),
    .cache_data_1_in       (cache_data_1_in),
    .read_command_out      (read_command_out),
    .read_response_out     (read_response_out),
    .read_data_0_out       (read_data_0_out),
    .read_data_1_out       (read_data_1_out),
    .outstanding_out       (outstanding_out),
    .drained_out           (drained_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) read_command_in[i] = '0;
    cache_miss_command_in = '0;
    cache_response_in     = '0;
    cache_data_0_in       = '0;
    cache_data_1_in       = '0;
  endtask

  function automatic CommandBufferLine mk_cmd(input logic [31:0] addr, input logic [7:0] tag,
                                              input logic [1:0] id);
    CommandBufferLine c;
    c = '0;
    c.valid = 1'b1;
    c.payload.cmd.address = addr;
    c.payload.cmd.tag = tag;
    c.payload.cmd.cu_id = id;
    c.payload.burst_length = 8'd1;
    return c;
  endfunction

  function automatic logic [N-1:0] ready_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = read_ready_out[i];
    return r;
  endfunction

  function automatic logic [3*N-1:0] hit_valid_vec();
    logic [3*N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i]       = read_response_out[i].valid;
      r[N+i]     = read_data_0_out[i].valid;
      r[2*N+i]   = read_data_1_out[i].valid;
    end
    return r;
  endfunction

  task automatic send_hit(input logic [1:0] id);
    cache_response_in = '0;
    cache_response_in.valid = 1'b1;
    cache_response_in.payload.cmd.cu_id = id;
    tick();
    cache_response_in = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    enabled_in = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1;
    checks++; if (drained_out !== 1'b1) begin failures++; $display("FAIL rst_drained: got %0h exp 1", drained_out); end
    checks++; if (outstanding_out !== 4'd0) begin failures++; $display("FAIL rst_outstanding: got %0d exp 0", outstanding_out); end
    checks++; if (cache_command_out !== '0) begin failures++; $display("FAIL rst_cache_cmd: got %0h exp 0", cache_command_out); end
    checks++; if (ready_vec() !== 4'b0000) begin failures++; $display("FAIL rst_ready: got %b exp 0000", ready_vec()); end
    checks++; if ({read_command_out.valid, hit_valid_vec()} !== '0) begin failures++; $display("FAIL rst_route_valids: got %0h exp 0", {read_command_out.valid, hit_valid_vec()}); end
    tick();
    rst_in = 1'b0;
    enabled_in = 1'b1;
    tick();
    tick();
    read_command_in[0] = mk_cmd(32'h10, 8'h1, 2'd0);
    read_command_in[1] = mk_cmd(32'h11, 8'h2, 2'd0);
    read_command_in[2] = mk_cmd(32'h12, 8'h3, 2'd0);
    tick();
    clear_inputs();
    tick();
    checks++; if (cache_command_out.valid !== 1'b1 || outstanding_out !== 4'd1) begin failures++; $display("FAIL pre_rst_traffic: got valid %0h out %0d exp 1 1", cache_command_out.valid, outstanding_out); end
    #2 rst_in = 1'b1;
    #1;
    checks++; if (cache_command_out.valid !== 1'b0) begin failures++; $display("FAIL midrst_cmd_valid: got %0h exp 0", cache_command_out.valid); end
    checks++; if (outstanding_out !== 4'd0) begin failures++; $display("FAIL midrst_outstanding: got %0d exp 0", outstanding_out); end
    checks++; if (drained_out !== 1'b1) begin failures++; $display("FAIL midrst_drained: got %0h exp 1", drained_out); end
    checks++; if (ready_vec() !== 4'b0000) begin failures++; $display("FAIL midrst_ready: got %b exp 0000", ready_vec()); end
    tick();
    rst_in = 1'b0;
    tick();
    tick();
    checks++; if (ready_vec() !== 4'b1111) begin failures++; $display("FAIL postrst_ready: got %b exp 1111", ready_vec()); end
    checks++; if (drained_out !== 1'b0) begin failures++; $display("FAIL postrst_drained: got %0h exp 0", drained_out); end
    checks++; if (cache_command_out.valid !== 1'b0) begin failures++; $display("FAIL postrst_queue_flushed: got %0h exp 0", cache_command_out.valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    enabled_in = 1'b1;
    tick();
    tick();
    for (int i = 0; i < N; i++) read_command_in[i] = mk_cmd(32'h100 + i, 8'(i), 2'd0);
    tick();
    clear_inputs();
    checks++; if (cache_command_out.valid !== 1'b0) begin failures++; $display("FAIL rr_latency: got valid %0h one cycle after push exp 0", cache_command_out.valid); end
    for (int k = 0; k < N; k++) begin
      tick();
      checks++;
      if (cache_command_out.valid !== 1'b1 || cache_command_out.payload.cmd.cu_id !== 2'(k) ||
          cache_command_out.payload.cmd.address !== 32'h100 + k) begin
        failures++;
        $display("FAIL rr_burst1_%0d: got valid %0h id %0d addr %0h exp 1 %0d %0h", k,
                 cache_command_out.valid, cache_command_out.payload.cmd.cu_id,
                 cache_command_out.payload.cmd.address, k, 32'h100 + k);
      end
    end
    tick();
    checks++; if (cache_command_out.valid !== 1'b0) begin failures++; $display("FAIL rr_idle: got %0h exp 0", cache_command_out.valid); end
    read_command_in[1] = mk_cmd(32'h201, 8'h0, 2'd0);
    read_command_in[3] = mk_cmd(32'h203, 8'h0, 2'd0);
    tick();
    clear_inputs();
    tick();
    checks++; if (cache_command_out.payload.cmd.cu_id !== 2'd1 || cache_command_out.valid !== 1'b1) begin failures++; $display("FAIL rr_burst2_a: got id %0d exp 1", cache_command_out.payload.cmd.cu_id); end
    tick();
    checks++; if (cache_command_out.payload.cmd.cu_id !== 2'd3 || cache_command_out.valid !== 1'b1) begin failures++; $display("FAIL rr_burst2_b: got id %0d exp 3", cache_command_out.payload.cmd.cu_id); end
    read_command_in[0] = mk_cmd(32'h300, 8'h0, 2'd0);
    read_command_in[3] = mk_cmd(32'h303, 8'h0, 2'd0);
    tick();
    clear_inputs();
    tick();
    checks++; if (cache_command_out.payload.cmd.cu_id !== 2'd0 || cache_command_out.valid !== 1'b1) begin failures++; $display("FAIL rr_wrap_a: got id %0d exp 0", cache_command_out.payload.cmd.cu_id); end
    tick();
    checks++; if (cache_command_out.payload.cmd.cu_id !== 2'd3 || cache_command_out.valid !== 1'b1) begin failures++; $display("FAIL rr_wrap_b: got id %0d exp 3", cache_command_out.payload.cmd.cu_id); end
    checks++; if (outstanding_out !== 4'd8) begin failures++; $display("FAIL rr_outstanding: got %0d exp 8", outstanding_out); end
  endtask

  task automatic test_outstanding_limit();
    int issued;
    int wrong_id;
    issued = 0;
    wrong_id = 0;
    do_reset();
    enabled_in = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 14; k++) begin
      if (k < 10) read_command_in[2] = mk_cmd(32'h400 + k, 8'(k), 2'd0);
      else read_command_in[2] = '0;
      tick();
      if (cache_command_out.valid === 1'b1) begin
        issued++;
        if (cache_command_out.payload.cmd.cu_id !== 2'd2) wrong_id++;
      end
    end
    clear_inputs();
    checks++; if (issued != 8) begin failures++; $display("FAIL lim_issued: got %0d exp 8", issued); end
    checks++; if (wrong_id != 0) begin failures++; $display("FAIL lim_cu_id: got %0d wrong ids exp 0", wrong_id); end
    checks++; if (outstanding_out !== 4'd8) begin failures++; $display("FAIL lim_outstanding: got %0d exp 8", outstanding_out); end
    send_hit(2'd2);
    checks++; if (cache_command_out.valid !== 1'b1 || cache_command_out.payload.cmd.address !== 32'h408) begin failures++; $display("FAIL lim_ninth: got valid %0h addr %0h exp 1 408", cache_command_out.valid, cache_command_out.payload.cmd.address); end
    checks++; if (outstanding_out !== 4'd8) begin failures++; $display("FAIL lim_after_hit: got %0d exp 8", outstanding_out); end
    tick();
    checks++; if (cache_command_out.valid !== 1'b0) begin failures++; $display("FAIL lim_tenth_held: got %0h exp 0", cache_command_out.valid); end
  endtask

  task automatic test_routing();
    do_reset();
    enabled_in = 1'b1;
    tick();
    tick();
    read_command_in[0] = mk_cmd(32'h500, 8'h0, 2'd0);
    read_command_in[1] = mk_cmd(32'h501, 8'h0, 2'd0);
    tick();
    clear_inputs();
    tick();
    tick();
    checks++; if (outstanding_out !== 4'd2) begin failures++; $display("FAIL route_setup: got %0d exp 2", outstanding_out); end
    cache_response_in.valid = 1'b1;
    cache_response_in.payload.cmd.cu_id = 2'd3;
    cache_response_in.payload.cmd.address = 32'hDEAD0003;
    cache_data_0_in.valid = 1'b1;
    cache_data_0_in.payload.cmd.cu_id = 2'd3;
    cache_data_0_in.payload.data = 64'hA5A5A5A5A5A5A5A5;
    cache_data_1_in.valid = 1'b1;
    cache_data_1_in.payload.cmd.cu_id = 2'd3;
    cache_data_1_in.payload.data = 64'h5A5A5A5A5A5A5A5A;
    tick();
    clear_inputs();
    checks++; if (hit_valid_vec() !== 12'b1000_1000_1000) begin failures++; $display("FAIL route_hit_valids: got %b exp 100010001000", hit_valid_vec()); end
    checks++; if (read_data_0_out[3].payload.data !== 64'hA5A5A5A5A5A5A5A5) begin failures++; $display("FAIL route_data0: got %0h exp a5a5a5a5a5a5a5a5", read_data_0_out[3].payload.data); end
    checks++; if (read_data_1_out[3].payload.data !== 64'h5A5A5A5A5A5A5A5A) begin failures++; $display("FAIL route_data1: got %0h exp 5a5a5a5a5a5a5a5a", read_data_1_out[3].payload.data); end
    checks++; if (read_response_out[0].payload.cmd.address !== 32'hDEAD0003) begin failures++; $display("FAIL route_broadcast: got %0h exp dead0003", read_response_out[0].payload.cmd.address); end
    checks++; if (read_command_out.valid !== 1'b0 || outstanding_out !== 4'd1) begin failures++; $display("FAIL route_after_hit: got miss %0h out %0d exp 0 1", read_command_out.valid, outstanding_out); end
    cache_miss_command_in = mk_cmd(32'hBEEF0001, 8'h11, 2'd1);
    tick();
    clear_inputs();
    checks++; if (read_command_out.valid !== 1'b1 || read_command_out.payload.cmd.cu_id !== 2'd1 ||
                  read_command_out.payload.cmd.address !== 32'hBEEF0001) begin
      failures++;
      $display("FAIL route_miss: got valid %0h id %0d addr %0h exp 1 1 beef0001", read_command_out.valid,
               read_command_out.payload.cmd.cu_id, read_command_out.payload.cmd.address);
    end
    checks++; if (hit_valid_vec() !== '0 || outstanding_out !== 4'd0) begin failures++; $display("FAIL route_after_miss: got hits %b out %0d exp 0 0", hit_valid_vec(), outstanding_out); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    enabled_in = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      read_command_in[0] = mk_cmd(32'h600 + k, 8'(k), 2'd0);
      tick();
    end
    clear_inputs();
    tick();
    tick();
    checks++; if (outstanding_out !== 4'd5) begin failures++; $display("FAIL simul_setup: got %0d exp 5", outstanding_out); end
    read_command_in[0] = mk_cmd(32'h6FF, 8'h0, 2'd0);
    tick();
    clear_inputs();
    send_hit(2'd0);
    checks++; if (cache_command_out.valid !== 1'b1 || outstanding_out !== 4'd5) begin failures++; $display("FAIL simul_net: got valid %0h out %0d exp 1 5", cache_command_out.valid, outstanding_out); end
    tick();
    checks++; if (outstanding_out !== 4'd5) begin failures++; $display("FAIL simul_hold: got %0d exp 5", outstanding_out); end
  endtask

  task automatic test_drain();
    do_reset();
    enabled_in = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      read_command_in[0] = mk_cmd(32'h700 + k, 8'(k), 2'd0);
      tick();
    end
    clear_inputs();
    tick();
    tick();
    checks++; if (outstanding_out !== 4'd3) begin failures++; $display("FAIL drain_setup: got %0d exp 3", outstanding_out); end
    read_command_in[1] = mk_cmd(32'h711, 8'h0, 2'd0);
    read_command_in[2] = mk_cmd(32'h712, 8'h0, 2'd0);
    enabled_in = 1'b0;
    tick();
    clear_inputs();
    checks++; if (ready_vec() !== 4'b0000 || drained_out !== 1'b0) begin failures++; $display("FAIL drain_enter: got ready %b drained %0h exp 0000 0", ready_vec(), drained_out); end
    tick();
    checks++; if (cache_command_out.valid !== 1'b1 || cache_command_out.payload.cmd.cu_id !== 2'd1) begin failures++; $display("FAIL drain_issue_a: got valid %0h id %0d exp 1 1", cache_command_out.valid, cache_command_out.payload.cmd.cu_id); end
    tick();
    checks++; if (cache_command_out.valid !== 1'b1 || cache_command_out.payload.cmd.cu_id !== 2'd2) begin failures++; $display("FAIL drain_issue_b: got valid %0h id %0d exp 1 2", cache_command_out.valid, cache_command_out.payload.cmd.cu_id); end
    checks++; if (outstanding_out !== 4'd5 || ready_vec() !== 4'b0000) begin failures++; $display("FAIL drain_inflight: got out %0d ready %b exp 5 0000", outstanding_out, ready_vec()); end
    tick();
    checks++; if (cache_command_out.valid !== 1'b0 || drained_out !== 1'b0) begin failures++; $display("FAIL drain_wait: got valid %0h drained %0h exp 0 0", cache_command_out.valid, drained_out); end
    cache_miss_command_in = mk_cmd(32'h700, 8'h0, 2'd0);
    send_hit(2'd0);
    cache_miss_command_in = '0;
    checks++; if (outstanding_out !== 4'd3) begin failures++; $display("FAIL drain_double_retire: got %0d exp 3", outstanding_out); end
    send_hit(2'd0);
    send_hit(2'd1);
    send_hit(2'd2);
    checks++; if (outstanding_out !== 4'd0 || drained_out !== 1'b0) begin failures++; $display("FAIL drain_last_retire: got out %0d drained %0h exp 0 0", outstanding_out, drained_out); end
    tick();
    checks++; if (drained_out !== 1'b1) begin failures++; $display("FAIL drain_done: got %0h exp 1", drained_out); end
    checks++; if (ready_vec() !== 4'b0000) begin failures++; $display("FAIL drain_disabled_ready: got %b exp 0000", ready_vec()); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_outstanding_limit();
    test_routing();
    test_simultaneous();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
